regfile_write_arbiter: RTL and testbench

- Shares the single write port (RW/BusW/RegWr) of the 32 x 64-bit RegisterFile between two writeback requesters, port 0 and port 1.
- Each port has a valid/ready handshake and its own small FIFO.
- Each cycle at most one queued write is issued to the register file, chosen by the arbiter.
- Sits between the execute/load writeback stages and RegisterFile; the register file's read ports are untouched.

---
 rtl/regfile_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
// regfile_write_arbiter: two queued writeback requesters share the RegisterFile write port.
// Define RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module regfile_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  Clk,
  input  logic                  ResetL,
  input  logic                  Req0Valid,
  output logic                  Req0Ready,
  input  logic [4:0]            Req0Reg,
  input  logic [DATA_WIDTH-1:0] Req0Data,
  input  logic                  Req1Valid,
  output logic                  Req1Ready,
  input  logic [4:0]            Req1Reg,
  input  logic [DATA_WIDTH-1:0] Req1Data,
  output logic [4:0]            RW,
  output logic [DATA_WIDTH-1:0] BusW,
  output logic                  RegWr,
  output logic                  Busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [4:0] ZERO_REG = 5'd31;

  logic [4:0]            regMem0  [DEPTH];
  logic [DATA_WIDTH-1:0] dataMem0 [DEPTH];
  logic [4:0]            regMem1  [DEPTH];
  logic [DATA_WIDTH-1:0] dataMem1 [DEPTH];

  logic [PTR_W-1:0] wrPtr0, rdPtr0, wrPtr1, rdPtr1;
  logic [CNT_W-1:0] count0, count0Next, count1, count1Next;
  logic             push0, push1, pop0, pop1;
  logic             nonEmpty0, nonEmpty1;
  logic             grant0, grant1;

  logic                  vld_p1;
  logic [4:0]            rw_p1;
  logic [DATA_WIDTH-1:0] busW_p1;

  // Enqueue: writes to X31 complete the handshake but never occupy a slot.
  assign push0 = Req0Valid && Req0Ready && (Req0Reg != ZERO_REG);
  assign push1 = Req1Valid && Req1Ready && (Req1Reg != ZERO_REG);

  assign nonEmpty0 = (count0 != '0);
  assign nonEmpty1 = (count1 != '0);

  assign pop0 = grant0;
  assign pop1 = grant1;

  assign count0Next = count0 + CNT_W'(push0) - CNT_W'(pop0);
  assign count1Next = count1 + CNT_W'(push1) - CNT_W'(pop1);

`ifdef RR_ARB_EN
  // lastGrant = 1 means port 1 was served last, so port 0 wins the next tie.
  logic lastGrant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (nonEmpty0 && nonEmpty1) begin
      grant0 = lastGrant;
      grant1 = !lastGrant;
    end else begin
      grant0 = nonEmpty0;
      grant1 = nonEmpty1;
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      lastGrant <= 1'b1;
    end else if (grant0 || grant1) begin
      lastGrant <= grant1;
    end
  end
`else
  assign grant0 = nonEmpty0;
  assign grant1 = nonEmpty1 && !nonEmpty0;
`endif

  // FIFO control state
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      wrPtr0    <= '0;
      rdPtr0    <= '0;
      count0    <= '0;
      wrPtr1    <= '0;
      rdPtr1    <= '0;
      count1    <= '0;
      Req0Ready <= 1'b0;
      Req1Ready <= 1'b0;
    end else begin
      if (push0) wrPtr0 <= wrPtr0 + PTR_W'(1);
      if (pop0)  rdPtr0 <= rdPtr0 + PTR_W'(1);
      if (push1) wrPtr1 <= wrPtr1 + PTR_W'(1);
      if (pop1)  rdPtr1 <= rdPtr1 + PTR_W'(1);
      count0    <= count0Next;
      count1    <= count1Next;
      // Ready looks only at the next count, so a drain never admits a same-cycle push.
      Req0Ready <= (count0Next < CNT_FULL);
      Req1Ready <= (count1Next < CNT_FULL);
    end
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge Clk) begin
    if (push0) begin
      regMem0[wrPtr0]  <= Req0Reg;
      dataMem0[wrPtr0] <= Req0Data;
    end
    if (push1) begin
      regMem1[wrPtr1]  <= Req1Reg;
      dataMem1[wrPtr1] <= Req1Data;
    end
  end

  // Issue stage p1: registered write-port drive, held stable across the negedge write
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      vld_p1  <= 1'b0;
      rw_p1   <= '0;
      busW_p1 <= '0;
    end else begin
      vld_p1 <= grant0 || grant1;
      if (grant0) begin
        rw_p1   <= regMem0[rdPtr0];
        busW_p1 <= dataMem0[rdPtr0];
      end else if (grant1) begin
        rw_p1   <= regMem1[rdPtr1];
        busW_p1 <= dataMem1[rdPtr1];
      end
    end
  end

  assign RW    = rw_p1;
  assign BusW  = busW_p1;
  assign RegWr = vld_p1;
  assign Busy  = nonEmpty0 || nonEmpty1 || vld_p1;

  grantOneHot: assert property (@(posedge Clk) disable iff (!ResetL) !(grant0 && grant1));
  noOverflow0: assert property (@(posedge Clk) disable iff (!ResetL) count0 <= CNT_FULL);
  noOverflow1: assert property (@(posedge Clk) disable iff (!ResetL) count1 <= CNT_FULL);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
// Randomized bench for regfile_write_arbiter, checked against a queue-based reference model
// plus a behavioural RegisterFile that captures writes on the negedge.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int DW    = 64;
`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          Clk    = 1'b0;
  logic          ResetL = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic          rdy0, rdy1;
  logic [4:0]    r0 = '0, r1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic [4:0]    RW;
  logic [DW-1:0] BusW;
  logic          RegWr, Busy;

  always #5 Clk = ~Clk;

  regfile_write_arbiter #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .ResetL(ResetL),
    .Req0Valid(v0), .Req0Ready(rdy0), .Req0Reg(r0), .Req0Data(d0),
    .Req1Valid(v1), .Req1Ready(rdy1), .Req1Reg(r1), .Req1Data(d1),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .Busy(Busy)
  );

  logic [DW-1:0] rf [32] = '{default: '0};
  always @(negedge Clk) begin
    if (ResetL && RegWr && RW != 5'd31) rf[RW] <= BusW;
  end

  typedef struct packed { logic [4:0] r; logic [DW-1:0] d; } entT;
  entT           q0[$], q1[$];
  bit            mRdy0, mRdy1, mRegWr, mBusy, mLast;
  logic [4:0]    mRW;
  logic [DW-1:0] mBusW;
  bit            xfer0, xfer1;
  int            checks = 0, errors = 0;
  int            pulseCnt = 0, acceptCnt = 0;
  logic [4:0]    issueLog[$];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    mRdy0 = 0; mRdy1 = 0; mRegWr = 0; mBusy = 0; mLast = 1;
    mRW = '0; mBusW = '0;
    xfer0 = 0; xfer1 = 0;
  endtask

  // One rising edge of the arbiter, straight from the written rules.
  task automatic modelEdge();
    bit  x0, x1;
    int  w;
    entT e;
    x0 = v0 && mRdy0;
    x1 = v1 && mRdy1;
    w  = -1;
    if (q0.size() > 0 && q1.size() > 0) w = RR ? (mLast ? 0 : 1) : 0;
    else if (q0.size() > 0) w = 0;
    else if (q1.size() > 0) w = 1;
    if (w >= 0) begin
      e = (w == 0) ? q0.pop_front() : q1.pop_front();
      mRW = e.r;
      mBusW = e.d;
      mLast = (w == 1);
    end
    mRegWr = (w >= 0);
    if (x0 && r0 != 5'd31) begin q0.push_back('{r0, d0}); acceptCnt++; end
    if (x1 && r1 != 5'd31) begin q1.push_back('{r1, d1}); acceptCnt++; end
    mRdy0 = (q0.size() < DEPTH);
    mRdy1 = (q1.size() < DEPTH);
    mBusy = (q0.size() > 0) || (q1.size() > 0) || mRegWr;
    xfer0 = x0;
    xfer1 = x1;
  endtask

  task automatic step();
    @(posedge Clk);
    if (ResetL) modelEdge();
    else begin xfer0 = 0; xfer1 = 0; end
    #1;
    if (RegWr) begin pulseCnt++; issueLog.push_back(RW); end
    checkVal("ready0", rdy0, mRdy0);
    checkVal("ready1", rdy1, mRdy1);
    checkVal("regwr", RegWr, mRegWr);
    checkVal("rw", RW, mRW);
    checkVal("busw", BusW, mBusW);
    checkVal("busy", Busy, mBusy);
  endtask

  // New request only once the previous one has transferred (hold rule).
  task automatic drivePorts(input int pct0, input int pct1, input bit allow31);
    if (!(v0 && !xfer0)) begin
      v0 = ($urandom_range(0, 99) < pct0);
      r0 = allow31 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 30));
      d0 = {$urandom, $urandom};
    end
    if (!(v1 && !xfer1)) begin
      v1 = ($urandom_range(0, 99) < pct1);
      r1 = allow31 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 30));
      d1 = {$urandom, $urandom};
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] expOrd [4];
    bit         saw1Low;
    bit         filled;

    // Reset release
    modelReset();
    repeat (3) step();
    checkVal("rst_regwr", RegWr, 0);
    checkVal("rst_busy", Busy, 0);
    #3 ResetL = 1'b1;
    #1;
    checkVal("rel_ready0_low", rdy0, 0);
    checkVal("rel_ready1_low", rdy1, 0);
    step();
    checkVal("rel_ready0_up", rdy0, 1);
    checkVal("rel_ready1_up", rdy1, 1);

    // Simultaneous requests, first tie after reset
    issueLog.delete();
    v0 = 1; r0 = 5'd1; d0 = 64'h10;
    v1 = 1; r1 = 5'd2; d1 = 64'h20;
    step();
    r0 = 5'd3; d0 = 64'h30;
    r1 = 5'd4; d1 = 64'h40;
    step();
    v0 = 0; v1 = 0;
    repeat (4) step();
    if (RR) expOrd = '{5'd1, 5'd2, 5'd3, 5'd4};
    else    expOrd = '{5'd1, 5'd3, 5'd2, 5'd4};
    checkVal("tie_count", issueLog.size(), 4);
    for (int i = 0; i < 4 && i < issueLog.size(); i++) checkVal("tie_order", issueLog[i], expOrd[i]);

    // Single write, idle arbiter
    v0 = 1; r0 = 5'd5; d0 = 64'habcd;
    step();
    checkVal("single_xfer", xfer0, 1);
    v0 = 0;
    step();
    checkVal("single_regwr", RegWr, 1);
    checkVal("single_rw", RW, 5);
    checkVal("single_busw", BusW, 64'habcd);
    step();
    checkVal("single_regwr_off", RegWr, 0);
    checkVal("single_rf5", rf[5], 64'habcd);

    // X31 is accepted and dropped
    checkVal("x31_ready", rdy0, 1);
    v0 = 1; r0 = 5'd31; d0 = 64'hffff;
    step();
    checkVal("x31_xfer", xfer0, 1);
    checkVal("x31_busy_now", Busy, 0);
    v0 = 0;
    repeat (2) step();
    checkVal("x31_regwr", RegWr, 0);
    checkVal("x31_busy", Busy, 0);
    checkVal("x31_rf31", rf[31], 0);

    // Backpressure: both ports streaming continuously
    pulseCnt = 0; acceptCnt = 0; saw1Low = 0;
    for (int i = 0; i < 40; i++) begin
      drivePorts(100, 100, 1'b0);
      step();
      if (!rdy1) saw1Low = 1;
    end
    v0 = 0; v1 = 0;
    repeat (8) step();
    checkVal("bp_ready1_fell", saw1Low, 1);
    checkVal("bp_pulses_vs_accepts", pulseCnt, acceptCnt);
    checkVal("bp_drained_busy", Busy, 0);

    // Reset with entries queued
    filled = 0;
    for (int i = 0; i < 20 && !filled; i++) begin
      drivePorts(100, 100, 1'b0);
      step();
      if (q0.size() + q1.size() >= 3) filled = 1;
    end
    checkVal("mid_fill_reached", filled, 1);
    #2;
    ResetL = 1'b0;
    v0 = 0; v1 = 0;
    modelReset();
    pulseCnt = 0;
    #1;
    checkVal("mid_regwr_drop", RegWr, 0);
    checkVal("mid_busy_drop", Busy, 0);
    checkVal("mid_ready0_drop", rdy0, 0);
    checkVal("mid_ready1_drop", rdy1, 0);
    repeat (2) step();
    ResetL = 1'b1;
    repeat (6) step();
    checkVal("mid_no_writes_after", pulseCnt, 0);

    // Random traffic including X31 requests
    pulseCnt = 0; acceptCnt = 0;
    for (int i = 0; i < 400; i++) begin
      drivePorts(60, 60, 1'b1);
      step();
    end
    v0 = 0; v1 = 0;
    repeat (8) step();
    checkVal("rand_pulses_vs_accepts", pulseCnt, acceptCnt);
    checkVal("rand_rf31", rf[31], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
